// File: rtl/byte_serializer.sv
// Byte-to-serial UART-style transmitter: pulls bytes from an upstream FIFO and
// sends start bit, 8 data bits LSB first, optional even parity, and a stop bit.
module byte_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       pop,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] baud_q, baud_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       tx_q, tx_d;
   logic       pop_q, pop_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] frame_count_q, frame_count_d;

   logic baud_last;
   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d       = state_q;
      baud_d        = baud_q + 8'd1;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      pop_d         = 1'b0;
      done_d        = 1'b0;
      frame_count_d = frame_count_q;

      case (state_q)
         S_IDLE: begin
            baud_d = 8'd0;
            if (enable && !fifo_empty) begin
               shift_d = fifo_data;
               state_d = S_START;
               pop_d   = 1'b1;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d    = 8'd0;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = 8'd0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = PARITY_EN ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               baud_d  = 8'd0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d        = 8'd0;
               state_d       = S_IDLE;
               done_d        = 1'b1;
               frame_count_d = frame_count_q + 8'd1;
            end
         end
         default: begin
            baud_d  = 8'd0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are derived from the next state so they are registered yet cycle-aligned.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[bit_idx_d];
         S_PARITY: tx_d = ^shift_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the shift register is a plain datapath register, cleared on reset so a restart never leaks old data.
         state_q       <= S_IDLE;
         baud_q        <= 8'd0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'd0;
         tx_q          <= 1'b1;
         pop_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         baud_q        <= baud_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         tx_q          <= tx_d;
         pop_q         <= pop_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign pop         = pop_q;
   assign tx          = tx_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Randomized bench for byte_serializer: one instance without and one with parity,
// each fed from a queue-modelled FIFO and checked against an ideal frame waveform.
module tb_byte_serializer;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] enable;
   logic [1:0] fifo_empty;
   logic [7:0] fd [2];
   logic       pop0, pop1, tx0, tx1, busy0, busy1, done0, done1;
   logic [7:0] fc0, fc1;
   logic [1:0] pop, tx, busy, done;
   logic [7:0] fc [2];

   assign pop   = {pop1, pop0};
   assign tx    = {tx1, tx0};
   assign busy  = {busy1, busy0};
   assign done  = {done1, done0};
   assign fc[0] = fc0;
   assign fc[1] = fc1;

   byte_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) u_plain (
      .clk(clk), .reset(reset), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
      .fifo_data(fd[0]), .pop(pop0), .tx(tx0), .busy(busy0), .done(done0), .frame_count(fc0)
   );

   byte_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) u_par (
      .clk(clk), .reset(reset), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
      .fifo_data(fd[1]), .pop(pop1), .tx(tx1), .busy(busy1), .done(done1), .frame_count(fc1)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_pop [2];
   logic [7:0] fc_exp [2];
   logic [7:0] popped [2];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ideal line level for frame bit slot idx: start, data LSB first, parity, stop.
   function automatic logic exp_bit(input logic [7:0] b, input bit par, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (par && idx == 9) return logic'($countones(b) % 2);
      return 1'b1;
   endfunction

   task automatic drive_fifo();
      fifo_empty[0] = (q0.size() == 0);
      fifo_empty[1] = (q1.size() == 0);
      fd[0] = (q0.size() > 0) ? q0[0] : 8'($urandom);
      fd[1] = (q1.size() > 0) ? q1[0] : 8'($urandom);
   endtask

   task automatic push(input int d, input logic [7:0] b);
      if (d == 0) q0.push_back(b);
      else        q1.push_back(b);
      drive_fifo();
   endtask

   // Advance to the next falling edge; the upstream FIFO drops its head when pop is seen.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (pop[0] && q0.size() > 0) popped[0] = q0.pop_front();
      if (pop[1] && q1.size() > 0) popped[1] = q1.pop_front();
      drive_fifo();
   endtask

   task automatic run_frame(input int d, input bit chk_gap, input bit disturb, output int waited);
      int         len;
      int         pc;
      bit         saved_en;
      logic [7:0] b;
      logic [63:0] otx, etx, obusy, opop, odone;
      len = (d == 1) ? 11 * C : 10 * C;
      otx = '0; etx = '0; obusy = '0; opop = '0; odone = '0;
      waited = 0;
      while (!pop[d] && waited < 200) begin
         cycle();
         waited++;
      end
      check("pop_seen", 64'(pop[d]), 64'd1);
      if (pop[d]) begin
         pc = cyc;
         b  = popped[d];
         if (chk_gap) check("frame_gap", 64'(pc - last_pop[d]), 64'(len + 1));
         last_pop[d] = pc;
         saved_en = enable[d];
         for (int k = 0; k < len; k++) begin
            otx[k]   = tx[d];
            obusy[k] = busy[d];
            opop[k]  = pop[d];
            odone[k] = done[d];
            etx[k]   = exp_bit(b, d == 1, k / C);
            if (disturb && k == len / 2) enable[d] = 1'b0;
            if (disturb && k == len - 3) enable[d] = saved_en;
            cycle();
         end
         fc_exp[d] = fc_exp[d] + 8'd1;
         check("tx_frame", otx, etx);
         check("busy_frame", obusy, (64'd1 << len) - 64'd1);
         check("pop_frame", opop, 64'd1);
         check("done_frame", odone, 64'd0);
         check("done_pulse", 64'(done[d]), 64'd1);
         check("busy_done", 64'(busy[d]), 64'd0);
         check("tx_done", 64'(tx[d]), 64'd1);
         check("frame_count", 64'(fc[d]), 64'(fc_exp[d]));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_tx"}, 64'(tx[d]), 64'd1);
         check({tag, "_busy"}, 64'(busy[d]), 64'd0);
         check({tag, "_pop"}, 64'(pop[d]), 64'd0);
         check({tag, "_done"}, 64'(done[d]), 64'd0);
         check({tag, "_fc"}, 64'(fc[d]), 64'(fc_exp[d]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         w;
      int         n;
      int         d;
      bit         any_pop, any_busy, any_low;
      logic [7:0] b;

      reset     = 1'b1;
      enable    = 2'b00;
      fc_exp[0] = 8'd0;
      fc_exp[1] = 8'd0;
      last_pop[0] = 0;
      last_pop[1] = 0;
      drive_fifo();
      cycle();
      cycle();
      check_idle_outputs("reset");
      reset = 1'b0;

      // Single 0xA5 frame: pop on the cycle after enabling, done 40 cycles after pop.
      push(0, 8'hA5);
      enable[0] = 1'b1;
      run_frame(0, 1'b0, 1'b0, w);
      check("a5_wait", 64'(w), 64'd1);

      // Disabled with data waiting: nothing may move for 100 cycles.
      enable[0] = 1'b0;
      push(0, 8'h3C);
      any_pop = 0; any_busy = 0; any_low = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         any_pop  |= pop[0];
         any_busy |= busy[0];
         any_low  |= ~tx[0];
      end
      check("hold_pop", 64'(any_pop), 64'd0);
      check("hold_busy", 64'(any_busy), 64'd0);
      check("hold_tx_low", 64'(any_low), 64'd0);
      enable[0] = 1'b1;
      run_frame(0, 1'b0, 1'b0, w);
      check("enable_wait", 64'(w), 64'd1);

      // Parity instance: 0x07 has odd weight, 0x03 even.
      push(1, 8'h07);
      push(1, 8'h03);
      enable[1] = 1'b1;
      run_frame(1, 1'b0, 1'b0, w);
      run_frame(1, 1'b1, 1'b0, w);

      // Three queued bytes back-to-back.
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      run_frame(0, 1'b0, 1'b0, w);
      run_frame(0, 1'b1, 1'b0, w);
      run_frame(0, 1'b1, 1'b1, w);

      // Random bursts on both instances with random idle gaps and mid-frame enable drops.
      for (int r = 0; r < 6; r++) begin
         d = r % 2;
         n = $urandom_range(2, 6);
         enable[d] = 1'b0;
         for (int i = 0; i < n; i++) push(d, 8'($urandom));
         for (int i = 0; i < int'($urandom_range(0, 5)); i++) cycle();
         enable[d] = 1'b1;
         for (int i = 0; i < n; i++) run_frame(d, i > 0, 1'($urandom % 2), w);
      end

      // Reset pulse while data bit 3 is on the line.
      b = 8'($urandom);
      push(0, b);
      w = 0;
      while (!pop[0] && w < 200) begin
         cycle();
         w++;
      end
      check("abort_pop_seen", 64'(pop[0]), 64'd1);
      for (int i = 0; i < 17; i++) cycle();
      check("abort_bit3", 64'(tx[0]), 64'(b[3]));
      #1 reset = 1'b1;
      fc_exp[0] = 8'd0;
      fc_exp[1] = 8'd0;
      #1;
      check_idle_outputs("async_reset");
      cycle();
      check_idle_outputs("held_reset");
      push(0, 8'($urandom));
      reset = 1'b0;
      run_frame(0, 1'b0, 1'b0, w);
      check("post_reset_wait", 64'(w), 64'd1);

      // 255 more frames make 256 since reset, so the counter must be back at zero.
      for (int i = 0; i < 255; i++) push(0, 8'($urandom));
      for (int i = 0; i < 255; i++) run_frame(0, 1'b1, 1'b0, w);
      check("wrap_zero", 64'(fc[0]), 64'd0);
      cycle();
      check("done_one_cycle", 64'(done[0]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts one even-parity bit after data bit 7.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  permits the start of new frames.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO holds no bytes.
REQ-007 SHALL have port fifo_data  input  8  upstream FIFO head byte, valid whenever fifo_empty=0.
REQ-008 SHALL have port pop  output  1  one-cycle request to remove the upstream head byte.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of frame.
REQ-012 SHALL have port frame_count  output  8  frames completed since reset, wraps 255->0.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-014 IDLE: tx=1, busy=0; on an edge with enable=1 and fifo_empty=0, SHALL capture fifo_data into the shift register and enter START.
REQ-015 pop SHALL be 1 for exactly the first START cycle, once per frame; never while fifo_empty was 1 at the capture edge.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: tx = XOR of the 8 captured bits for CLKS_PER_BIT cycles, then STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; on the last STOP cycle's edge go to IDLE, pulse done for one cycle, increment frame_count mod 256.
REQ-020 busy SHALL be 1 in START, DATA, PARITY and STOP, else 0.
REQ-021 Baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state/bit change, and never skip or repeat a bit.
REQ-022 Frame length SHALL be exactly (10+PARITY_EN)*CLKS_PER_BIT cycles from the first START cycle to the done cycle inclusive-exclusive; minimum gap between frames is one IDLE cycle (done cycle).
REQ-023 Back-to-back: with fifo_empty=0 in the done cycle, the next frame's START SHALL begin the following cycle.
REQ-024 enable or fifo_empty changing mid-frame SHALL NOT affect the current frame; fifo_data changes after capture are ignored.
REQ-025 enable=0 in IDLE SHALL hold IDLE with pop=0 regardless of fifo_empty.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, tx=1, pop=0, busy=0, done=0, frame_count=0, shift register, bit index and baud counter to 0.
REQ-027 reset asserted mid-frame SHALL abort it without done and without frame_count increment; tx SHALL go high without waiting for clk.
REQ-028 After reset deassertion, first possible capture SHALL be the first rising clk edge with reset=0.

Verification (CLKS_PER_BIT=4)
REQ-029 fifo_data=0xA5, fifo_empty=0, enable=1 for one capture -> pop one cycle; tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; done at cycle 40; frame_count=1.
REQ-030 PARITY_EN=1, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-031 Three bytes queued (0x11,0x22,0x33), fifo_empty=0 throughout -> three pops 41 cycles apart, three done pulses, frame_count=3, tx never idles more than 1 cycle between frames.
REQ-032 enable=0, fifo_empty=0 for 100 cycles -> pop=0, tx=1, busy=0; enable=1 -> pop next cycle.
REQ-033 reset pulsed during DATA bit 3 -> tx=1, busy=0, frame_count=0 immediately, no done; next frame starts cleanly.
REQ-034 frame_count after 256 frames -> 0, done pulses still one cycle each.
